// File: rtl/pe_feed_pkg.sv
// Shared types and width helpers for the PE array feed controller.
// Holds the FSM state type, element/window width functions and the FIFO pointer width.
package pe_feed_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WLOAD  = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   function automatic int rw_f(input int dw, input int ww);
      return dw + ww;
   endfunction

   function automatic int win_f(input int w, input int k);
      return w * k * k;
   endfunction

   function automatic int ptr_f(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/pe_feed_res_fifo.sv
// Result FIFO between the PE array and the result handshake.
// Ports: clk, rstn (sync, active-low), push/push_data, pop/pop_data, empty, count.
module pe_feed_res_fifo
   import pe_feed_pkg::*;
#(
   parameter int WIDTH = 28,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          pop_data,
   output logic                      empty,
   output logic [ptr_f(DEPTH):0]     count
);

   localparam int PW = ptr_f(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full    = (cnt_q == CW'(DEPTH));
      empty   = (cnt_q == '0);
      do_pop  = pop && !empty;
      // a push into a full FIFO is only taken when the head leaves this cycle
      do_push = push && (!full || do_pop);
      wr_d    = wr_q + PW'(do_push);
      rd_d    = rd_q + PW'(do_pop);
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = push_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign pop_data = mem_q[rd_q];
   assign count    = cnt_q;

endmodule

// File: rtl/pe_feed_ctrl.sv
// Feeds weights and data windows to a PE array and collects its results.
// Ports: w_*/d_*/r_* handshakes, array side (weight_array, dataIn, enables, done, pe_dataOut),
// busy, timeout_err. Optional watchdog: define PE_FEED_TIMEOUT_EN.
module pe_feed_ctrl
   import pe_feed_pkg::*;
#(
   parameter int WEIGHT_WIDTH   = 1,
   parameter int DATA_WIDTH     = 8,
   parameter int KERNEL_SIZE    = 3,
   parameter int RES_FIFO_DEPTH = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                                clk,
   input  logic                                                rstn,
   input  logic                                                w_valid,
   output logic                                                w_ready,
   input  logic [win_f(WEIGHT_WIDTH, KERNEL_SIZE)-1:0]         w_data,
   input  logic                                                d_valid,
   output logic                                                d_ready,
   input  logic [win_f(DATA_WIDTH, KERNEL_SIZE)-1:0]           d_data,
   input  logic                                                d_last,
   output logic [win_f(WEIGHT_WIDTH, KERNEL_SIZE)-1:0]         weight_array,
   output logic                                                wr_weight_en,
   output logic [win_f(DATA_WIDTH, KERNEL_SIZE)-1:0]           dataIn,
   output logic                                                wr_dataIn_en,
   input  logic                                                wr_weight_done,
   input  logic                                                pe_array_done,
   input  logic [rw_f(DATA_WIDTH, WEIGHT_WIDTH)*KERNEL_SIZE-1:0] pe_dataOut,
   output logic                                                r_valid,
   input  logic                                                r_ready,
   output logic [rw_f(DATA_WIDTH, WEIGHT_WIDTH)*KERNEL_SIZE-1:0] r_data,
   output logic                                                r_last,
   output logic                                                busy,
   output logic                                                timeout_err
);

   localparam int WW  = win_f(WEIGHT_WIDTH, KERNEL_SIZE);
   localparam int DWW = win_f(DATA_WIDTH, KERNEL_SIZE);
   localparam int RWW = rw_f(DATA_WIDTH, WEIGHT_WIDTH) * KERNEL_SIZE;
   localparam int FW  = RWW + 1;
   localparam int CW  = ptr_f(RES_FIFO_DEPTH) + 1;

   if ((RES_FIFO_DEPTH < 2) ||
       ((RES_FIFO_DEPTH & (RES_FIFO_DEPTH - 1)) != 0) ||
       (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("pe_feed_ctrl: bad parameter");
   end

   state_t         state_q, state_d;
   logic [WW-1:0]  weight_q, weight_d;
   logic [DWW-1:0] data_q, data_d;
   logic           den_q, den_d;
   logic [CW-1:0]  outst_q, outst_d;
   logic [CW-1:0]  fifo_cnt;
   logic [CW:0]    credit;
   logic [FW-1:0]  head;
   logic           fifo_empty;
   logic           w_acc;
   logic           acc;
   logic           done_eff;
   logic           push_last;
   logic           tmo_hit;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (w_acc) state_d = WLOAD;
         WLOAD:  if (wr_weight_done) state_d = STREAM;
         STREAM: if (acc && d_last) state_d = DRAIN;
         DRAIN:  if (outst_d == '0) state_d = IDLE;
      endcase
      if (tmo_hit) state_d = IDLE;
   end

   always_comb begin
      credit       = {1'b0, outst_q} + {1'b0, fifo_cnt};
      w_ready      = rstn && (state_q == IDLE);
      wr_weight_en = rstn && (state_q != IDLE);
      busy         = rstn && (state_q != IDLE);
      d_ready      = rstn && (state_q == STREAM) && wr_weight_done &&
                     (credit < (CW+1)'(RES_FIFO_DEPTH));
      wr_dataIn_en = rstn && den_q;
      r_valid      = rstn && !fifo_empty;
      r_data       = r_valid ? head[RWW-1:0] : '0;
      r_last       = r_valid && head[RWW];
   end

   always_comb begin
      w_acc     = w_valid && w_ready;
      acc       = d_valid && d_ready;
      // done with nothing in flight is a stray pulse from the array
      done_eff  = pe_array_done && (outst_q != '0);
      push_last = (state_q == DRAIN) && (outst_q == CW'(1));
      weight_d  = w_acc ? w_data : weight_q;
      data_d    = acc ? d_data : data_q;
      den_d     = acc;
      outst_d   = outst_q + CW'(acc) - CW'(done_eff);
      if (tmo_hit) outst_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         weight_q <= '0;
         data_q   <= '0;
         den_q    <= 1'b0;
         outst_q  <= '0;
      end else begin
         weight_q <= weight_d;
         data_q   <= data_d;
         den_q    <= den_d;
         outst_q  <= outst_d;
      end
   end

   assign weight_array = weight_q;
   assign dataIn       = data_q;

`ifdef PE_FEED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          terr_q, terr_d;

   always_comb begin
      tmo_hit = (outst_q != '0) && !pe_array_done &&
                (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
      if ((outst_q == '0) || pe_array_done || tmo_hit) tcnt_d = '0;
      else                                             tcnt_d = tcnt_q + TW'(1);
      terr_d = terr_q || tmo_hit;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tcnt_q <= '0;
         terr_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         terr_q <= terr_d;
      end
   end

   assign timeout_err = rstn && terr_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   pe_feed_res_fifo #(
      .WIDTH (FW),
      .DEPTH (RES_FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (done_eff),
      .push_data ({push_last, pe_dataOut}),
      .pop       (r_valid && r_ready),
      .pop_data  (head),
      .empty     (fifo_empty),
      .count     (fifo_cnt)
   );

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Directed bench for pe_feed_ctrl with a 4-cycle PE array model.
// Timeout steps run only when PE_FEED_TIMEOUT_EN is defined.
module tb_pe_feed_ctrl;

   logic         clk = 1'b0;
   logic         rstn;
   logic         w_valid, w_ready;
   logic [8:0]   w_data;
   logic         d_valid, d_ready, d_last;
   logic [71:0]  d_data;
   logic [8:0]   weight_array;
   logic         wr_weight_en;
   logic [71:0]  dataIn;
   logic         wr_dataIn_en;
   logic         wr_weight_done;
   logic         pe_array_done;
   logic [26:0]  pe_dataOut;
   logic         r_valid, r_ready, r_last;
   logic [26:0]  r_data;
   logic         busy, timeout_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic arr_en = 1'b1;

   logic [3:0]  pv;
   logic [26:0] pd [4];

   always #5 clk = ~clk;

   pe_feed_ctrl dut (
      .clk(clk), .rstn(rstn),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_last(d_last),
      .weight_array(weight_array), .wr_weight_en(wr_weight_en),
      .dataIn(dataIn), .wr_dataIn_en(wr_dataIn_en),
      .wr_weight_done(wr_weight_done), .pe_array_done(pe_array_done),
      .pe_dataOut(pe_dataOut),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
      .busy(busy), .timeout_err(timeout_err)
   );

   // array model: weight load takes one cycle, each window returns 4 cycles later
   always @(posedge clk) begin
      wr_weight_done <= rstn && wr_weight_en;
      if (!rstn || !arr_en) begin
         pv <= '0;
      end else begin
         pv    <= {pv[2:0], wr_dataIn_en};
         pd[0] <= dataIn[26:0];
         pd[1] <= pd[0];
         pd[2] <= pd[1];
         pd[3] <= pd[2];
      end
   end
   assign pe_array_done = pv[3];
   assign pe_dataOut    = pd[3];

   function automatic logic [71:0] win(input int k);
      return 72'(k) * 72'h0123_4567 + 72'h55;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_w(input logic [8:0] w);
      w_valid = 1'b1;
      w_data  = w;
      step();
      w_valid = 1'b0;
   endtask

   task automatic send_win(input logic [71:0] v, input logic last);
      int i;
      d_valid = 1'b1;
      d_data  = v;
      d_last  = last;
      for (i = 0; i < 100; i++) begin
         if (d_ready) break;
         step();
      end
      chk("send_wait", d_ready, 1'b1);
      step();
      d_valid = 1'b0;
      d_last  = 1'b0;
   endtask

   task automatic get_res(input logic [71:0] v, input logic last);
      int i;
      logic [71:0] ev;
      ev = v;
      for (i = 0; i < 100; i++) begin
         if (r_valid) break;
         step();
      end
      chk("res_wait", r_valid, 1'b1);
      chk("res_data", r_data, ev[26:0]);
      chk("res_last", r_last, last);
      r_ready = 1'b1;
      step();
      r_ready = 1'b0;
   endtask

   initial begin
      int sent, got, i;
      logic acc_now, pop_now, seen;
      logic [71:0] ev;

      rstn = 1'b0; w_valid = 1'b0; w_data = '0;
      d_valid = 1'b0; d_data = '0; d_last = 1'b0; r_ready = 1'b0;
      #1;
      chk("rst_w_ready_pre", w_ready, 1'b0);
      step(); step();
      chk("rst_w_ready", w_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_d_ready", d_ready, 1'b0);
      chk("rst_r_valid", r_valid, 1'b0);
      chk("rst_wen", wr_weight_en, 1'b0);
      chk("rst_weight", weight_array, 9'h0);
      chk("rst_tmo", timeout_err, 1'b0);
      rstn = 1'b1;
      step();
      chk("post_rst_w_ready", w_ready, 1'b1);

      // single-window job
      load_w(9'h1FF);
      chk("j1_wen", wr_weight_en, 1'b1);
      chk("j1_weight", weight_array, 9'h1FF);
      chk("j1_busy", busy, 1'b1);
      chk("j1_w_ready", w_ready, 1'b0);
      send_win(win(1), 1'b1);
      chk("j1_den", wr_dataIn_en, 1'b1);
      chk("j1_dataIn", dataIn, win(1));
      chk("j1_d_ready_drain", d_ready, 1'b0);
      step();
      chk("j1_den_pulse", wr_dataIn_en, 1'b0);
      seen = 1'b0;
      for (i = 0; i < 50; i++) begin
         if (pe_array_done) begin seen = 1'b1; break; end
         step();
      end
      chk("j1_done_wait", seen, 1'b1);
      chk("j1_busy_at_done", busy, 1'b1);
      step();
      chk("j1_busy_after", busy, 1'b0);
      get_res(win(1), 1'b1);
      chk("j1_empty", r_valid, 1'b0);

      // 8-window job with backpressure
      load_w(9'h0A5);
      w_data = 9'h000;
      for (int k = 0; k < 4; k++) send_win(win(10 + k), 1'b0);
      chk("j2_credit_stop", d_ready, 1'b0);
      for (i = 0; i < 12; i++) step();
      chk("j2_still_stop", d_ready, 1'b0);
      chk("j2_r_valid", r_valid, 1'b1);
      chk("j2_weight_hold", weight_array, 9'h0A5);
      sent = 4; got = 0;
      d_valid = 1'b1; d_data = win(14); d_last = 1'b0;
      r_ready = 1'b1;
      for (i = 0; i < 400 && got < 8; i++) begin
         acc_now = d_valid && d_ready;
         pop_now = r_valid && r_ready;
         if (pop_now) begin
            ev = win(10 + got);
            chk("j2_data", r_data, ev[26:0]);
            chk("j2_last", r_last, (got == 7));
            got++;
         end
         step();
         if (acc_now) begin
            sent++;
            if (sent < 8) begin
               d_data = win(10 + sent);
               d_last = (sent == 7);
            end else begin
               d_valid = 1'b0;
               d_last  = 1'b0;
            end
         end
      end
      r_ready = 1'b0;
      chk("j2_count", got, 8);
      chk("j2_idle", busy, 1'b0);
      chk("j2_empty", r_valid, 1'b0);

      // reset in the middle of a job
      load_w(9'h111);
      for (int k = 0; k < 3; k++) send_win(win(20 + k), 1'b0);
      step(); step();
      rstn = 1'b0;
      step();
      chk("mr_w_ready", w_ready, 1'b0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_d_ready", d_ready, 1'b0);
      chk("mr_r_valid", r_valid, 1'b0);
      chk("mr_r_last", r_last, 1'b0);
      chk("mr_wen", wr_weight_en, 1'b0);
      chk("mr_den", wr_dataIn_en, 1'b0);
      chk("mr_weight", weight_array, 9'h0);
      chk("mr_dataIn", dataIn, 72'h0);
      chk("mr_tmo", timeout_err, 1'b0);
      rstn = 1'b1;
      step();
      chk("mr_w_ready_after", w_ready, 1'b1);
      load_w(9'h0F0);
      send_win(win(30), 1'b1);
      get_res(win(30), 1'b1);
      seen = 1'b0;
      for (i = 0; i < 10; i++) begin
         if (r_valid) seen = 1'b1;
         step();
      end
      chk("mr_no_extra", seen, 1'b0);
      chk("mr_idle", busy, 1'b0);
      chk("no_tmo", timeout_err, 1'b0);

`ifdef PE_FEED_TIMEOUT_EN
      arr_en = 1'b0;
      load_w(9'h00F);
      send_win(win(40), 1'b1);
      for (i = 0; i < 63; i++) step();
      chk("to_before", timeout_err, 1'b0);
      chk("to_busy_before", busy, 1'b1);
      step();
      chk("to_flag", timeout_err, 1'b1);
      chk("to_idle", busy, 1'b0);
      chk("to_w_ready", w_ready, 1'b1);
      chk("to_no_push", r_valid, 1'b0);
      load_w(9'h003);
      chk("to_new_job", busy, 1'b1);
      chk("to_sticky", timeout_err, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pe_feed_ctrl.md
PE_FEED_CTRL -- requirements
Module: pe_feed_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WEIGHT_WIDTH, 1, bits per weight.
- DATA_WIDTH, 8, bits per data element.
- KERNEL_SIZE, 3, kernel edge; one window is KERNEL_SIZE*KERNEL_SIZE elements.
- RES_FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 64, watchdog limit, used only under REQ-022.
REQ-002 Ports, one per line: name, direction, width, meaning. RW = DATA_WIDTH+WEIGHT_WIDTH.
- clk, in, 1, clock.
- rstn, in, 1, reset; synchronous, active-low.
- w_valid / w_ready, in / out, 1, weight-set handshake.
- w_data, in, WEIGHT_WIDTH*KERNEL_SIZE^2, weight set.
- d_valid / d_ready, in / out, 1, data-window handshake.
- d_data, in, DATA_WIDTH*KERNEL_SIZE^2, one window.
- d_last, in, 1, marks the final window of a job.
- weight_array, out, WEIGHT_WIDTH*KERNEL_SIZE^2, to the array.
- wr_weight_en, out, 1, to the array.
- dataIn, out, DATA_WIDTH*KERNEL_SIZE^2, to the array.
- wr_dataIn_en, out, 1, to the array.
- wr_weight_done, in, 1, from the array.
- pe_array_done, in, 1, from the array.
- pe_dataOut, in, RW*KERNEL_SIZE, from the array.
- r_valid / r_ready, out / in, 1, result handshake.
- r_data, out, RW*KERNEL_SIZE, result row.
- r_last, out, 1, marks the final result of a job.
- busy, out, 1, high whenever state != IDLE.
- timeout_err, out, 1, sticky watchdog flag.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, WLOAD, STREAM, DRAIN.
REQ-004 IDLE: w_ready=1; on w_valid&&w_ready, latch w_data into weight_array and go to WLOAD.
REQ-005 WLOAD: drive wr_weight_en=1; on wr_weight_done=1, go to STREAM.
REQ-006 wr_weight_en SHALL stay 1 in WLOAD, STREAM and DRAIN, and 0 in IDLE. weight_array SHALL stay constant outside IDLE.
REQ-007 STREAM: d_ready = wr_weight_done && (outstanding + fifo_count < RES_FIFO_DEPTH).
REQ-008 On d_valid&&d_ready, register d_data into dataIn and pulse wr_dataIn_en for exactly one cycle on the next cycle; one window is accepted per cycle maximum.
REQ-009 An accepted window with d_last=1 SHALL move the FSM to DRAIN; d_ready=0 in DRAIN.
REQ-010 outstanding SHALL increment on accept and decrement on each pe_array_done=1 cycle. Accept and done in the same cycle leave it unchanged.
REQ-011 Each pe_array_done=1 cycle SHALL push pe_dataOut into the result FIFO.
REQ-012 r_last SHALL be 1 on the entry pushed while in DRAIN with outstanding==1.
REQ-013 DRAIN -> IDLE when outstanding==0; the FIFO may still hold results and keeps draining.
REQ-014 The result FIFO SHALL never overflow, guaranteed by the REQ-007 credit check. Push and pop in the same cycle SHALL be legal at any occupancy.
REQ-015 r_valid = FIFO not empty; r_data/r_last = head entry; pop on r_valid&&r_ready.
REQ-016 A pe_array_done=1 cycle while outstanding==0 SHALL be ignored, with no push.
REQ-017 Accept-to-push latency is set by the array; this block adds no extra cycles beyond REQ-008 registration.

Reset
REQ-018 rstn low SHALL force: state=IDLE, outstanding=0, FIFO empty.
REQ-019 rstn low SHALL drive to 0: wr_weight_en, wr_dataIn_en, weight_array, dataIn, r_valid, r_last, busy, timeout_err, d_ready. w_ready SHALL be 0 during reset and 1 on the first cycle after it.
REQ-020 Reset mid-job SHALL discard in-flight windows and stored results without emitting any partial result.

Configuration
REQ-021 Macro PE_FEED_TIMEOUT_EN selects the watchdog.
REQ-022 With PE_FEED_TIMEOUT_EN defined:
- A counter runs while outstanding>0 and clears on every pe_array_done.
- When it reaches TIMEOUT_CYCLES: set timeout_err (sticky until reset), clear outstanding, go to IDLE. FIFO contents are kept.
REQ-023 Without PE_FEED_TIMEOUT_EN: timeout_err is tied to 0, no counter logic is present, and TIMEOUT_CYCLES is unused.

Structure
REQ-024 Package pe_feed_pkg SHALL hold the state typedef (IDLE/WLOAD/STREAM/DRAIN), the RW and window-width localparam functions, and the FIFO pointer width function.
REQ-025 The result FIFO SHALL be the sub-module pe_feed_res_fifo, with width RW*KERNEL_SIZE+1 and depth RES_FIFO_DEPTH.

Verification
REQ-026 Single-window job: w_data all ones, one window with d_last=1, array model with 4-cycle latency. Expect exactly one result, with r_last=1; busy falls 1 cycle after the done.
REQ-027 8-window job, r_ready held 0: d_ready drops after 4 accepts (depth 4). Releasing r_ready yields 8 results in order, r_last only on the 8th.
REQ-028 Accept and pe_array_done in the same cycle: outstanding is unchanged. Push and pop on a full FIFO: count stays 4, no data lost.
REQ-029 Reset asserted 2 cycles after the 3rd accept: all outputs 0 next cycle. The next job's first result is not stale data.
REQ-030 With PE_FEED_TIMEOUT_EN, the array model never asserts done: timeout_err=1 at accept+64 cycles, FSM in IDLE, and a new w_valid is accepted.
